// File: rtl/mem_stall_responder.sv
// mem_stall_responder: behavioural data-memory target with a one-line
// "last-access" buffer. Hits and illegal requests complete in the request
// cycle; misses stall for MISS_LAT cycles, then complete and refill the line.
module mem_stall_responder #(
  parameter int MEM_WORDS = 256,
  parameter int MISS_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(MISS_LAT - 2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_valid;
  logic [12:0]    r_tag;
  logic [15:0]    r_mem [MEM_WORDS];

  // copy of the miss request, held while the requester is stalled
  logic [AW-1:0]  r_word;
  logic [12:0]    r_ltag;
  logic           r_lwr;
  logic [15:0]    r_ldata;

  logic           w_req;
  logic           w_err;
  logic           w_legal;
  logic           w_hit;
  logic [AW-1:0]  w_word;
  logic [12:0]    w_tag;
  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic [15:0]    w_wdata;
  logic           w_unused;

  // createdump is a simulation hook only; it never touches state
  assign w_unused = createdump;

  assign w_word  = Addr[AW:1];
  assign w_tag   = Addr[15:3];
  assign w_req   = Rd ^ Wr;
  assign w_err   = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign w_legal = w_req & ~Addr[0];
  assign w_hit   = w_legal & r_valid & (r_tag == w_tag);

  // a hit write lands in the request cycle, a miss write when it completes
  assign w_we    = ((r_state == S_IDLE) & w_hit & Wr) |
                   ((r_state == S_RESP) & r_lwr);
  assign w_waddr = (r_state == S_RESP) ? r_word  : w_word;
  assign w_wdata = (r_state == S_RESP) ? r_ldata : DataIn;

  // storage array: cleared on reset, write-through from either path
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // request sequencing: IDLE accepts, BUSY counts down the miss, RESP refills
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_word  <= '0;
      r_ltag  <= '0;
      r_lwr   <= 1'b0;
      r_ldata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_legal && !w_hit) begin
            r_word  <= w_word;
            r_ltag  <= w_tag;
            r_lwr   <= Wr;
            r_ldata <= DataIn;
            r_cnt   <= CNT_LOAD;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          r_valid <= 1'b1;
          r_tag   <= r_ltag;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // response outputs: hits and errors answer combinationally in IDLE
  always_comb begin
    DataOut  = '0;
    Done     = 1'b0;
    Stall    = 1'b0;
    CacheHit = 1'b0;
    err      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_err) begin
          err  = 1'b1;
          Done = 1'b1;
        end else if (w_hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          if (Rd) DataOut = r_mem[w_word];
        end else if (w_legal) begin
          Stall = 1'b1;
        end
      end
      S_BUSY: Stall = 1'b1;
      S_RESP: begin
        Done = 1'b1;
        if (!r_lwr) DataOut = r_mem[r_word];
      end
      default: ;
    endcase
  end

  // handshake invariants
  a_stall_done: assert property (@(posedge clk) disable iff (rst) !(Stall && Done));
  a_hit_done:   assert property (@(posedge clk) disable iff (rst) CacheHit |-> Done);
  a_err_done:   assert property (@(posedge clk) disable iff (rst) err |-> (Done && !Stall));

endmodule

// File: tb/tb_mem_stall_responder.sv
// Randomized scoreboard bench for mem_stall_responder. The driver predicts each
// response from a word-array/line model and queues it; the monitor pops on Done.
module tb_mem_stall_responder;

  localparam int LAT = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] Addr = 0, DataIn = 0;
  logic        Rd = 0, Wr = 0, createdump = 0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;

  // second instance at the minimum latency, driven by its own directed phase
  logic        rst2 = 1;
  logic [15:0] Addr2 = 0, DataIn2 = 0;
  logic        Rd2 = 0, Wr2 = 0;
  logic [15:0] DataOut2;
  logic        Done2, Stall2, CacheHit2, err2;

  mem_stall_responder #(.MEM_WORDS(256), .MISS_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err));

  mem_stall_responder #(.MEM_WORDS(256), .MISS_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst2), .Addr(Addr2), .DataIn(DataIn2), .Rd(Rd2), .Wr(Wr2),
    .createdump(createdump), .DataOut(DataOut2), .Done(Done2), .Stall(Stall2),
    .CacheHit(CacheHit2), .err(err2));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        hit;
    logic        er;
    int          stall;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // reference model: word array plus the single line buffer
  logic [15:0] m_mem [256];
  logic        m_valid;
  logic [12:0] m_tag;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
    m_valid = 0;
    m_tag   = '0;
    q.delete();
  endtask

  // monitor: count stall cycles per request and check each completion
  int stall_run = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_run = 0;
      end else begin
        chk("invariants", {Stall & Done, CacheHit & ~Done, err & ~Done,
                           (DataOut != 0) & ~Done}, 0);
        if (Stall) stall_run++;
        if (stall_run > 40) begin
          chk("stall_bound", stall_run, 40);
          stall_run = 0;
        end
        if (Done) begin
          if (q.size() == 0) begin
            chk("spurious_done", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("DataOut", DataOut, e.data);
            chk("CacheHit", CacheHit, e.hit);
            chk("err", err, e.er);
            chk("stall_cycles", stall_run, e.stall);
          end
          stall_run = 0;
        end
      end
    end
  end

  // issue one request at posedge+1, hold until Done, release after the edge
  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic scr = 0,
                     input logic [15:0] sa = 0, input logic [15:0] sd = 0);
    exp_t e;
    int   k;
    logic [7:0] idx;
    idx = a[8:1];
    e.data = 0; e.hit = 0; e.er = 0; e.stall = 0;
    if ((rd && wr) || ((rd || wr) && a[0])) begin
      e.er = 1;
    end else if (m_valid && m_tag == a[15:3]) begin
      e.hit = 1;
      if (rd) e.data = m_mem[idx];
      else    m_mem[idx] = d;
    end else begin
      e.stall = LAT;
      if (rd) e.data = m_mem[idx];
      else    m_mem[idx] = d;
      m_valid = 1;
      m_tag   = a[15:3];
    end
    q.push_back(e);
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (Done) break;
      k++;
      if (scr && k == 2) begin
        Addr = sa; DataIn = sd;
      end
      if (k > 40) begin
        chk("done_timeout", k, 0);
        q.delete();
        break;
      end
    end
    @(posedge clk); #1;
    Rd = 0; Wr = 0;
  endtask

  task automatic do_reset();
    Rd = 0; Wr = 0; rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    chk("reset_outputs", {DataOut, Done, Stall, CacheHit, err}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // plain miss, write-then-hit on the same line
    req(1, 0, 16'h0010, 0);
    req(0, 1, 16'h0020, 16'hBEEF);
    req(1, 0, 16'h0022, 0);
    req(1, 0, 16'h0020, 0);

    // illegal requests leave state untouched
    req(1, 0, 16'h0013, 0);
    req(1, 1, 16'h0040, 0);
    req(1, 0, 16'h0040, 0);

    // requester inputs changing during BUSY must not affect the write
    req(0, 1, 16'h0100, 16'h1234, 1, 16'h0200, 16'hFFFF);
    req(1, 0, 16'h0200, 0);
    req(1, 0, 16'h0100, 0);

    // reset in the middle of a miss write aborts it
    Wr = 1; Addr = 16'h0080; DataIn = 16'h5555;
    @(posedge clk); @(posedge clk); #1;
    rst = 1; Wr = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    chk("abort_outputs", {DataOut, Done, Stall, CacheHit, err}, 0);
    @(posedge clk); #1;
    req(1, 0, 16'h0080, 0);

    // randomized traffic over a small address window so lines get reused
    for (int n = 0; n < 250; n++) begin
      logic [15:0] a;
      int op;
      a  = 16'(($urandom_range(0, 15) << 3) | ($urandom_range(0, 3) << 1));
      if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
      op = $urandom_range(0, 15);
      if (op == 0)     req(1, 1, a, 16'($urandom));
      else if (op < 8) req(1, 0, a, 16'($urandom));
      else             req(0, 1, a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    // minimum-latency instance: stall 2 cycles, then same-line hit at once
    rst2 = 0;
    Addr2 = 16'h0030; Rd2 = 1;
    @(negedge clk);
    chk("L2_c0_stall", {Stall2, Done2}, 2'b10);
    @(negedge clk);
    chk("L2_c1_stall", {Stall2, Done2}, 2'b10);
    @(negedge clk);
    chk("L2_c2_done", {Stall2, Done2, CacheHit2, err2}, 4'b0100);
    chk("L2_c2_data", DataOut2, 0);
    @(posedge clk); #1;
    Addr2 = 16'h0032;
    @(negedge clk);
    chk("L2_hit", {Stall2, Done2, CacheHit2, err2}, 4'b0110);
    @(posedge clk); #1;
    Rd2 = 0;
    @(negedge clk);
    chk("L2_idle", {DataOut2, Done2, Stall2, CacheHit2, err2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // hard bound on total runtime
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
